mvu_pe_out_buf: RTL and testbench

- Downstream of the PE accumulators in the MVAU batch datapath.
- Captures the PE-wide accumulator result each time the accumulators assert their output-valid pulse.
- Buffers results in a small circular FIFO and presents them on an AXI4-Stream master port with full ready/valid backpressure.
- Raises a stall request to the MVAU control block before the FIFO fills, and flags any lost result.

---
 rtl/mvu_pe_out_buf.sv | 111 +++++++++++
 tb/tb_mvu_pe_out_buf.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mvu_pe_out_buf.sv
// mvu_pe_out_buf: result buffer between the MVAU PE accumulators and an
// AXI4-Stream master port.
//
// Each in_acc_v pulse captures one PE-wide accumulator word into a small
// circular FIFO. The FIFO head is presented on m_axis_* with full ready/valid
// backpressure. A stall request is raised once occupancy reaches STALL_TH.
// A word that arrives while the FIFO is full and nothing is draining is
// dropped, and ovf_err latches until reset.
//
// Ports:
//   aclk, aresetn   clock, synchronous active-low reset
//   in_acc_v        single-cycle result-valid pulse
//   in_acc          packed lane results, lane p at [p*TDstI +: TDstI]
//   m_axis_tvalid   output word valid (FIFO non-empty)
//   m_axis_tready   downstream ready
//   m_axis_tdata    FIFO head word, same packing as in_acc
//   stall           occupancy >= STALL_TH
//   ovf_err         sticky dropped-result flag
//   occupancy       current entry count
module mvu_pe_out_buf #(
    parameter int unsigned PE         = 2,
    parameter int unsigned TDstI      = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned STALL_TH   = 3
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic                               in_acc_v,
    input  logic [PE*TDstI-1:0]                in_acc,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic [PE*TDstI-1:0]                m_axis_tdata,
    output logic                               stall,
    output logic                               ovf_err,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    occupancy
);

    localparam int unsigned DATA_W = PE * TDstI;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [OCC_W-1:0]  r_occ;
    logic              r_tvalid;
    logic              r_stall;
    logic              r_ovf;

    logic              w_rd;
    logic              w_full;
    logic              w_wr;
    logic              w_drop;
    logic [OCC_W-1:0]  w_occ_nxt;

    // Handshake decode; a full FIFO still accepts a write when the head drains
    assign w_rd   = r_tvalid & m_axis_tready;
    assign w_full = (r_occ == OCC_W'(FIFO_DEPTH));
    assign w_wr   = in_acc_v & (~w_full | w_rd);
    assign w_drop = in_acc_v & w_full & ~w_rd;

    // Next occupancy
    always_comb begin
        w_occ_nxt = r_occ;
        if (w_wr && !w_rd) begin
            w_occ_nxt = r_occ + OCC_W'(1);
        end else if (w_rd && !w_wr) begin
            w_occ_nxt = r_occ - OCC_W'(1);
        end
    end

    // Storage array; contents are don't-care after reset
    always_ff @(posedge aclk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= in_acc;
        end
    end

    // Pointers, occupancy and status flags; tvalid/stall are registered
    // from next occupancy so they track r_occ exactly with no ready path
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_tvalid <= 1'b0;
            r_stall  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_occ    <= w_occ_nxt;
            r_tvalid <= (w_occ_nxt != '0);
            r_stall  <= (w_occ_nxt >= OCC_W'(STALL_TH));
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = r_mem[r_rd_ptr];
    assign stall         = r_stall;
    assign ovf_err       = r_ovf;
    assign occupancy     = r_occ;

endmodule

// File: tb/tb_mvu_pe_out_buf.sv
// Self-checking bench for mvu_pe_out_buf: directed scenarios plus a random
// phase, all checked against a queue-based reference model.
module tb_mvu_pe_out_buf;

    localparam int unsigned PE         = 2;
    localparam int unsigned TDstI      = 16;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned STALL_TH   = 3;
    localparam int unsigned DATA_W     = PE * TDstI;
    localparam int unsigned OCC_W      = $clog2(FIFO_DEPTH + 1);

    logic              aclk = 1'b0;
    logic              aresetn;
    logic              in_acc_v;
    logic [DATA_W-1:0] in_acc;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              stall;
    logic              ovf_err;
    logic [OCC_W-1:0]  occupancy;

    mvu_pe_out_buf #(
        .PE(PE), .TDstI(TDstI), .FIFO_DEPTH(FIFO_DEPTH), .STALL_TH(STALL_TH)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .in_acc_v      (in_acc_v),
        .in_acc        (in_acc),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .stall         (stall),
        .ovf_err       (ovf_err),
        .occupancy     (occupancy)
    );

    always #5 aclk = ~aclk;

    // Reference model: FIFO contents as a queue, plus the sticky drop flag
    logic [DATA_W-1:0] m_q[$];
    bit                m_ovf;
    int                n_total;
    int                n_bad;
    int                n_xfer;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".tvalid"}, 64'(m_axis_tvalid), 64'(m_q.size() != 0));
        check({tag, ".occ"},    64'(occupancy),     64'(m_q.size()));
        check({tag, ".stall"},  64'(stall),         64'(m_q.size() >= STALL_TH));
        check({tag, ".ovf"},    64'(ovf_err),       64'(m_ovf));
        if (m_q.size() != 0) begin
            check({tag, ".tdata"}, 64'(m_axis_tdata), 64'(m_q[0]));
        end
    endtask

    // Drive one cycle of inputs (at negedge), advance the model across the
    // posedge, then check outputs at the following negedge
    task automatic tick(input string tag, input logic rst_n, input logic v,
                        input logic [DATA_W-1:0] d, input logic rdy);
        bit full;
        bit rd;
        aresetn       = rst_n;
        in_acc_v      = v;
        in_acc        = d;
        m_axis_tready = rdy;
        @(posedge aclk);
        if (!rst_n) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            full = (m_q.size() == FIFO_DEPTH);
            rd   = (m_q.size() != 0) && rdy;
            if (rd) begin
                void'(m_q.pop_front());
                n_xfer++;
            end
            if (v) begin
                if (!full || rd) m_q.push_back(d);
                else             m_ovf = 1'b1;
            end
        end
        @(negedge aclk);
        check_all(tag);
    endtask

    task automatic do_reset();
        tick("rst", 1'b0, 1'b0, '0, 1'b0);
        tick("rst", 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        n_total = 0; n_bad = 0; n_xfer = 0; m_ovf = 1'b0;
        aresetn = 1'b0; in_acc_v = 1'b0; in_acc = '0; m_axis_tready = 1'b0;
        @(negedge aclk);

        // Reset state
        do_reset();
        check("reset.tvalid", 64'(m_axis_tvalid), 64'd0);
        check("reset.occ",    64'(occupancy),     64'd0);

        // Single write: visible next cycle, drains one cycle later
        tick("single.wr", 1'b1, 1'b1, 32'h0005_FFFD, 1'b1);
        check("single.tdata", 64'(m_axis_tdata), 64'h0005_FFFD);
        tick("single.rd", 1'b1, 1'b0, '0, 1'b1);
        check("single.empty", 64'(occupancy), 64'd0);

        // Fill with backpressure, stall from the cycle after the third write
        for (int i = 1; i <= 4; i++) begin
            tick("fill", 1'b1, 1'b1, DATA_W'(i), 1'b0);
            if (i == 3) check("fill.stall3", 64'(stall), 64'd1);
        end
        check("fill.occ4", 64'(occupancy), 64'd4);

        // Overflow: write while full and not draining is dropped
        tick("ovf.wr9", 1'b1, 1'b1, 32'd9, 1'b0);
        check("ovf.flag", 64'(ovf_err), 64'd1);
        for (int i = 1; i <= 4; i++) begin
            check("drain.order", 64'(m_axis_tdata), 64'(i));
            tick("drain", 1'b1, 1'b0, '0, 1'b1);
        end
        check("drain.sticky", 64'(ovf_err), 64'd1);
        do_reset();
        check("ovf.cleared", 64'(ovf_err), 64'd0);

        // Full with a simultaneous read and write: both accepted
        for (int i = 1; i <= 4; i++) tick("fill2", 1'b1, 1'b1, DATA_W'(10 + i), 1'b0);
        tick("full.rdwr7", 1'b1, 1'b1, 32'd7, 1'b1);
        check("full.occ", 64'(occupancy), 64'd4);
        check("full.noovf", 64'(ovf_err), 64'd0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) check("full.seven4th", 64'(m_axis_tdata), 64'd7);
            tick("drain2", 1'b1, 1'b0, '0, 1'b1);
        end

        // Random traffic with a control block that honours stall
        for (int c = 0; c < 2000; c++) begin
            logic v;
            v = !stall && ($urandom_range(1) == 1);
            tick("rand", 1'b1, v, DATA_W'($urandom), 1'($urandom_range(1)));
        end
        for (int c = 0; c < 8; c++) tick("rand.drain", 1'b1, 1'b0, '0, 1'b1);
        check("rand.empty", 64'(occupancy), 64'd0);
        check("rand.noovf", 64'(ovf_err), 64'd0);
        check("rand.wrapped", 64'(n_xfer > 100), 64'd1);

        // Reset with three entries buffered discards them
        for (int i = 0; i < 3; i++) tick("pre", 1'b1, 1'b1, DATA_W'(32'hA0 + i), 1'b0);
        tick("midrst", 1'b0, 1'b0, '0, 1'b0);
        check("midrst.tvalid", 64'(m_axis_tvalid), 64'd0);
        check("midrst.occ", 64'(occupancy), 64'd0);
        tick("post.wr", 1'b1, 1'b1, 32'hBEEF_0001, 1'b0);
        check("post.first", 64'(m_axis_tdata), 64'hBEEF_0001);
        tick("post.rd", 1'b1, 1'b0, '0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
